// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Gated-window frequency meter. Counts rising edges of an
//                asynchronous clock over GATE_CYCLES system clocks, in
//                single-shot or back-to-back continuous windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   meas_clk_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   valid_o,
  output logic                   overflow_o
);

  localparam int                    GATE_WIDTH = $clog2(GATE_CYCLES);
  localparam logic [GATE_WIDTH-1:0] GATE_LAST  = GATE_WIDTH'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sync_q;
  logic [GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic                   edge_pulse;
  logic [COUNT_WIDTH-1:0] acc_cnt;
  logic                   acc_sat;

  // Two-flop synchronizer plus a delay stage for rising-edge detection; free-running.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], meas_clk_i};
    end
  end

  assign edge_pulse = sync_q[1] & ~sync_q[2];

  // Saturating accumulation of this cycle's edge pulse into the running window count.
  always_comb begin
    acc_cnt = edge_cnt_q;
    acc_sat = sat_q;
    if (edge_pulse) begin
      if (&edge_cnt_q) begin
        acc_sat = 1'b1;
      end else begin
        acc_cnt = edge_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Next-state and output logic; the result is captured on the last gate cycle so it is visible in DONE.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_MEASURE;
          gate_d     = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      ST_MEASURE: begin
        busy_o     = 1'b1;
        gate_d     = gate_q + GATE_WIDTH'(1);
        edge_cnt_d = acc_cnt;
        sat_d      = acc_sat;
        if (gate_q == GATE_LAST) begin
          state_d = ST_DONE;
          count_d = acc_cnt;
          ovf_d   = acc_sat;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        gate_d = '0;
        if (continuous_i) begin
          // The DONE cycle opens the next window, so its edge is not lost.
          busy_o     = 1'b1;
          state_d    = ST_MEASURE;
          edge_cnt_d = edge_pulse ? COUNT_WIDTH'(1) : '0;
          sat_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and result registers; reset discards any partial window.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Directed self-checking bench for freq_meter with a
//                result scoreboard filled at stimulus time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int CW   = 4;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          meas_clk_i;
  logic          start_i;
  logic          continuous_i;
  logic          busy_o;
  logic [CW-1:0] count_o;
  logic          valid_o;
  logic          overflow_o;

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   got[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   meas_period = 0;
  logic meas_level  = 1'b0;
  int   phase       = 0;

  freq_meter #(
    .GATE_CYCLES (GATE),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .meas_clk_i   (meas_clk_i),
    .start_i      (start_i),
    .continuous_i (continuous_i),
    .busy_o       (busy_o),
    .count_o      (count_o),
    .valid_o      (valid_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle index, stable when sampled on the falling edge.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Measured clock: period in clk_i cycles, or a constant level when the period is 0.
  always @(negedge clk_i) begin
    if (meas_period == 0) begin
      meas_clk_i <= meas_level;
      phase      <= 0;
    end else begin
      meas_clk_i <= (phase < meas_period / 2);
      phase      <= (phase + 1) % meas_period;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Scoreboard consumer: every valid_o pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        chk("valid_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_rng("count", int'(count_o), e.lo, e.hi);
          chk("overflow", overflow_o, e.ovf);
          chk("valid_cycle", cyc, e.cyc);
          got.push_back(int'(count_o));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_exp(input int lo, input int hi, input logic ovf, input int c);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ovf;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_o !== 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_in_time", (sb.size() == 0 && busy_o === 1'b0) ? 32'd1 : 32'd0, 32'd1);
    sb.delete();
  endtask

  task automatic single(input int lo, input int hi, input logic ovf);
    int s;
    s = cyc;
    push_exp(lo, hi, ovf, s + GATE + 1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    drain(GATE + 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    int s;
    int sum;
    int n;
    arst_ni      = 1'b0;
    start_i      = 1'b0;
    continuous_i = 1'b0;
    tick(3);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    arst_ni = 1'b1;
    tick(2);

    // Single shot, period 10: latency and busy window.
    meas_period = 10;
    tick(30);
    s = cyc;
    push_exp(10, 10, 1'b0, s + GATE + 1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    chk("busy_first", busy_o, 1);
    tick(GATE - 1);
    chk("busy_last", busy_o, 1);
    tick(1);
    chk("busy_done", busy_o, 0);
    drain(20);
    tick(1);
    chk("valid_one_cycle", valid_o, 0);
    chk("count_held", count_o, 10);

    // Constant input levels give zero edges.
    meas_period = 0;
    meas_level  = 1'b0;
    tick(20);
    single(0, 0, 1'b0);
    meas_level = 1'b1;
    tick(20);
    single(0, 0, 1'b0);

    // Saturation, then recovery with a slower input.
    meas_period = 4;
    tick(20);
    single(15, 15, 1'b1);
    meas_period = 20;
    tick(40);
    single(5, 5, 1'b0);
    tick(5);
    chk("count_held_5", count_o, 5);
    chk("ovf_cleared", overflow_o, 0);

    // Start pulses during MEASURE must not restart the window.
    meas_period = 10;
    tick(30);
    s = cyc;
    push_exp(10, 10, 1'b0, s + GATE + 1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    repeat (5) begin
      tick(15);
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
    end
    drain(GATE + 20);

    // Continuous: back-to-back windows of GATE+1 cycles, then a graceful stop.
    meas_period = 8;
    tick(30);
    continuous_i = 1'b1;
    got.delete();
    s = cyc;
    for (int i = 0; i < 10; i++) push_exp(12, 13, 1'b0, s + (GATE + 1) * (i + 1));
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    n = 0;
    while (got.size() < 9 && n < 10 * (GATE + 1)) begin
      tick(1);
      n++;
    end
    chk("cont_nine_windows", (got.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
    tick(50);
    continuous_i = 1'b0;
    drain(2 * GATE);
    chk("cont_window_count", got.size(), 10);
    sum = 0;
    for (int i = 1; i <= 8 && i < got.size(); i++) sum += got[i];
    chk_rng("cont_sum8", sum, 100, 102);
    tick(150);
    chk("cont_stopped", busy_o, 0);

    // Reset in mid-window aborts without a result.
    meas_period = 10;
    tick(30);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(49);
    arst_ni = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", valid_o, 0);
    chk("abort_count", count_o, 0);
    chk("abort_ovf", overflow_o, 0);
    tick(5);
    arst_ni = 1'b1;
    tick(150);
    chk("abort_idle", busy_o, 0);
    single(10, 10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
